branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
Resolves conditional branches (opcode 1100011) in execute and closes the loop with the fetch-side branch predictor.
- Holds in-flight predictions (taken bit, both candidate PCs, predictor class index) in an in-order FIFO.
- On each resolution, computes the actual outcome from the operands and funct3, and returns the training pair (branch, flag, class) to the predictor.
- On a mispredict, raises a multi-cycle flush and a redirect PC.

Parameters:
ADDR_W, 5, instruction address width (matches the predictor's 5-bit PC).
CLS_W, 3, predictor class-index width (the predictor's count field).
DEPTH, 4, in-flight prediction FIFO entries (power of two, >=2).
FLUSH_CYC, 2, cycles flush stays asserted after a mispredict (>=1).

Ports:
clk  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
pred_valid  in  1  predictor issued a prediction this cycle
pred_taken  in  1  predicted direction
pred_target  in  ADDR_W  taken-path PC (current+offset)
pred_fallthru  in  ADDR_W  not-taken PC (current+1)
pred_cls  in  CLS_W  predictor class index used
pred_ready  out  1  FIFO can accept (not full and not flushing)
res_valid  in  1  execute resolving the oldest branch
res_funct3  in  3  branch condition
res_rs1  in  32  operand 1
res_rs2  in  32  operand 2
upd_branch  out  1  one-cycle training strobe to predictor
upd_flag  out  1  actual outcome
upd_cls  out  CLS_W  class to train
flush  out  1  kill younger instructions
redirect_valid  out  1  one-cycle pulse, redirect_pc valid
redirect_pc  out  ADDR_W  correct next PC
res_err  out  1  one-cycle pulse: illegal funct3 or resolve with empty FIFO
fifo_count  out  clog2(DEPTH)+1  occupancy
resolve_cnt  out  8  branches resolved, saturating
mispred_cnt  out  8  mispredicts, saturating

Behaviour:
- Reset (resetn low, async): FIFO empty, state IDLE, and every output is 0 except pred_ready=1. Counters are 0. Reset asserted mid-flush aborts the flush immediately.
- Push: occurs when pred_valid && pred_ready. Pushing with pred_ready=0 drops the prediction; the predictor must hold it.
- Pop: occurs on res_valid with a non-empty FIFO, and takes the head entry.
  - When full, a pop and push in the same cycle are both accepted. pred_ready still reads 0 that cycle (it is computed from registered occupancy).
- Outcome by funct3:
  - 000 BEQ: rs1==rs2.
  - 001 BNE: rs1!=rs2.
  - 100 BLT: signed rs1<rs2.
  - 101 BGE: signed rs1>=rs2.
  - 110 BLTU: unsigned rs1<rs2.
  - 111 BGEU: unsigned rs1>=rs2.
  - 010 and 011: outcome=0 and res_err pulses. The entry is still popped and trained.
- Latency: all outputs are registered, one cycle after the pop edge.
  - upd_branch=1, upd_flag=outcome, upd_cls=head.cls.
- Mispredict (outcome != head.pred_taken):
  - redirect_valid=1 for one cycle.
  - redirect_pc = outcome ? head.target : head.fallthru.
  - mispred_cnt increments.
- FSM:
  - IDLE -> FLUSH on a mispredict pop.
  - FLUSH holds FLUSH_CYC cycles (internal down-counter), then returns to IDLE.
  - flush=1 exactly in the FLUSH state, starting the same cycle as redirect_valid.
  - On the IDLE->FLUSH edge the FIFO is cleared. Any push in that same cycle is discarded, since those are wrong-path entries.
  - In FLUSH: pred_ready=0, and res_valid is ignored (no pop, no update, no err).
- Correct prediction: updates only; no flush, no redirect.
- res_valid with empty FIFO (in IDLE): no pop, no update, res_err pulses.
- Counters: resolve_cnt increments on every accepted pop. Both counters saturate at 255 (no wrap).
- FIFO pointers: wrap modulo DEPTH. fifo_count runs from 0 to DEPTH.

Decomposition:
- Shared package: funct3 constants (F3_BEQ..F3_BGEU), branch opcode 7'b1100011, and a state enum {IDLE, FLUSH}.
- One sub-module is natural: pred_fifo. It is a synchronous DEPTH x (1+2*ADDR_W+CLS_W) FIFO with push/pop/clear/count and an async active-low reset.
- Compare logic and the FSM stay in branch_resolver.

Test Plan:
1. Reset, then push {taken=1, target=5'd12, fallthru=5'd4, cls=3}; resolve BEQ with rs1=rs2=7 -> next cycle upd_branch=1, upd_flag=1, upd_cls=3, flush=0, redirect_valid=0, resolve_cnt=1.
2. Push {taken=1, target=20, fallthru=9, cls=1}; resolve BLT with rs1=5, rs2=-3 (signed) -> upd_flag=0, redirect_valid=1, redirect_pc=9, flush high for exactly 2 cycles, fifo_count=0, mispred_cnt=1.
3. Fill 4 entries -> pred_ready=0, fifo_count=4. Then pop and push in the same cycle -> both accepted, fifo_count stays 4, order preserved on subsequent pops.
4. During a flush, drive res_valid and pred_valid -> no update, no err, FIFO stays empty. The first push after flush drops is accepted.
5. res_valid with empty FIFO -> res_err=1 for one cycle, upd_branch=0. Then push and resolve with funct3=010 -> res_err=1, upd_flag=0, entry popped.
6. Resolve 300 correctly predicted BGEU branches (rs1=0xFFFFFFFF, rs2=1, pred_taken=1) -> resolve_cnt=255, mispred_cnt=0. Assert resetn low mid-flush -> all outputs 0 at once, pred_ready=1.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the conditional-branch resolver.
// Contents: the branch opcode, the funct3 condition codes, the resolver
// state enum, and a helper that flags the funct3 values with no branch
// condition.
package branch_resolver_pkg;

    // Major opcode of RV32 conditional branches
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 branch conditions
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Resolver control state
    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

    // 010 and 011 have no branch condition assigned
    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

endpackage

// File: rtl/branch_resolver_pred_fifo.sv
// In-order FIFO of in-flight branch predictions.
// Ports:
//   clk, resetn   clock and asynchronous active-low reset
//   push_i        write wdata_i at the tail (caller guarantees space or a same-cycle pop)
//   pop_i         drop the head entry (caller guarantees non-empty)
//   clear_i       empty the FIFO; overrides push/pop in the same cycle
//   wdata_i       entry to write
//   rdata_o       head entry, valid while not empty
//   count_o       occupancy, 0..DEPTH
//   empty_o       occupancy is zero
//   full_o        occupancy is DEPTH
module branch_resolver_pred_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 14
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Pointer/occupancy update; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
            if (pop_i)  rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
            case ({push_i, pop_i})
                2'b10:   count_d = CNT_W'(count_q + CNT_W'(1));
                2'b01:   count_d = CNT_W'(count_q - CNT_W'(1));
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as occupied
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/branch_resolver.sv
// Resolves conditional branches in execute against the predictions issued
// by fetch, trains the predictor and redirects fetch on a mispredict.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   pred_valid/pred_taken/pred_target/pred_fallthru/pred_cls
//                               prediction issued by fetch
//   pred_ready                  a prediction can be accepted this cycle
//   res_valid/res_funct3/res_rs1/res_rs2
//                               execute resolving the oldest branch
//   upd_branch/upd_flag/upd_cls one-cycle training strobe, outcome, class
//   flush                       kill younger instructions
//   redirect_valid/redirect_pc  one-cycle redirect with the correct next PC
//   res_err                     one-cycle pulse: illegal funct3 or empty resolve
//   fifo_count                  in-flight prediction count
//   resolve_cnt/mispred_cnt     saturating event counters
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned CLS_W     = 3,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      pred_valid,
    input  logic                      pred_taken,
    input  logic [ADDR_W-1:0]         pred_target,
    input  logic [ADDR_W-1:0]         pred_fallthru,
    input  logic [CLS_W-1:0]          pred_cls,
    output logic                      pred_ready,
    input  logic                      res_valid,
    input  logic [2:0]                res_funct3,
    input  logic [31:0]               res_rs1,
    input  logic [31:0]               res_rs2,
    output logic                      upd_branch,
    output logic                      upd_flag,
    output logic [CLS_W-1:0]          upd_cls,
    output logic                      flush,
    output logic                      redirect_valid,
    output logic [ADDR_W-1:0]         redirect_pc,
    output logic                      res_err,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic [7:0]                resolve_cnt,
    output logic [7:0]                mispred_cnt
);

    localparam int unsigned ENT_W  = 1 + 2 * ADDR_W + CLS_W;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned FCNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    br_state_e          state_q, state_d;
    logic [FCNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic               upd_branch_q, upd_branch_d;
    logic               upd_flag_q, upd_flag_d;
    logic [CLS_W-1:0]   upd_cls_q, upd_cls_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic [ADDR_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic               res_err_q, res_err_d;
    logic [7:0]         resolve_cnt_q, resolve_cnt_d;
    logic [7:0]         mispred_cnt_q, mispred_cnt_d;

    logic [ENT_W-1:0]   head_c;
    logic [ENT_W-1:0]   wdata_c;
    logic [CNT_W-1:0]   count_c;
    logic               empty_c, full_c;
    logic               idle_c, outcome_c, illegal_c;
    logic               pop_c, push_c, mispred_c;

    logic               head_taken_c;
    logic [ADDR_W-1:0]  head_target_c;
    logic [ADDR_W-1:0]  head_fallthru_c;
    logic [CLS_W-1:0]   head_cls_c;

    // Entry layout, MSB first: {taken, target, fallthru, cls}
    assign wdata_c         = {pred_taken, pred_target, pred_fallthru, pred_cls};
    assign head_taken_c    = head_c[ENT_W-1];
    assign head_target_c   = head_c[ENT_W-2 -: ADDR_W];
    assign head_fallthru_c = head_c[ADDR_W+CLS_W-1 -: ADDR_W];
    assign head_cls_c      = head_c[CLS_W-1:0];

    branch_resolver_pred_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_pred_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .clear_i (mispred_c),
        .wdata_i (wdata_c),
        .rdata_o (head_c),
        .count_o (count_c),
        .empty_o (empty_c),
        .full_o  (full_c)
    );

    // Actual branch outcome from funct3 and the operands
    always_comb begin
        outcome_c = 1'b0;
        illegal_c = f3_illegal(res_funct3);
        case (res_funct3)
            F3_BEQ:  outcome_c = (res_rs1 == res_rs2);
            F3_BNE:  outcome_c = (res_rs1 != res_rs2);
            F3_BLT:  outcome_c = ($signed(res_rs1) <  $signed(res_rs2));
            F3_BGE:  outcome_c = ($signed(res_rs1) >= $signed(res_rs2));
            F3_BLTU: outcome_c = (res_rs1 <  res_rs2);
            F3_BGEU: outcome_c = (res_rs1 >= res_rs2);
            default: outcome_c = 1'b0;
        endcase
    end

    // Next state, FIFO control and registered-output next values
    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        upd_branch_d     = 1'b0;
        upd_flag_d       = 1'b0;
        upd_cls_d        = '0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
        res_err_d        = 1'b0;
        resolve_cnt_d    = resolve_cnt_q;
        mispred_cnt_d    = mispred_cnt_q;

        idle_c    = (state_q == IDLE);
        pop_c     = idle_c && res_valid && !empty_c;
        mispred_c = pop_c && (outcome_c != head_taken_c);
        // A full FIFO still takes a push when the head leaves in the same
        // cycle; pushes alongside a mispredict are wrong-path and dropped.
        push_c    = idle_c && pred_valid && (!full_c || pop_c) && !mispred_c;

        case (state_q)
            IDLE: begin
                if (mispred_c) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FCNT_W'(FLUSH_CYC - 1);
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = FCNT_W'(flush_cnt_q - FCNT_W'(1));
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop_c) begin
            upd_branch_d = 1'b1;
            upd_flag_d   = outcome_c;
            upd_cls_d    = head_cls_c;
            if (resolve_cnt_q != 8'hFF) resolve_cnt_d = 8'(resolve_cnt_q + 8'd1);
        end

        if (mispred_c) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = outcome_c ? head_target_c : head_fallthru_c;
            if (mispred_cnt_q != 8'hFF) mispred_cnt_d = 8'(mispred_cnt_q + 8'd1);
        end

        res_err_d = idle_c && res_valid && (empty_c || illegal_c);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= IDLE;
            flush_cnt_q      <= '0;
            upd_branch_q     <= 1'b0;
            upd_flag_q       <= 1'b0;
            upd_cls_q        <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            res_err_q        <= 1'b0;
            resolve_cnt_q    <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            upd_branch_q     <= upd_branch_d;
            upd_flag_q       <= upd_flag_d;
            upd_cls_q        <= upd_cls_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            res_err_q        <= res_err_d;
            resolve_cnt_q    <= resolve_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
        end
    end

    // pred_ready and flush decode registered state/occupancy only
    assign pred_ready     = (state_q == IDLE) && !full_c;
    assign flush          = (state_q == FLUSH);
    assign fifo_count     = count_c;
    assign upd_branch     = upd_branch_q;
    assign upd_flag       = upd_flag_q;
    assign upd_cls        = upd_cls_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign res_err        = res_err_q;
    assign resolve_cnt    = resolve_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: stimulus queues expected update
// events; a negedge monitor pops and compares whenever the DUT strobes.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pred_valid, pred_taken;
    logic [4:0]  pred_target, pred_fallthru;
    logic [2:0]  pred_cls;
    logic        pred_ready;
    logic        res_valid;
    logic [2:0]  res_funct3;
    logic [31:0] res_rs1, res_rs2;
    logic        upd_branch, upd_flag;
    logic [2:0]  upd_cls;
    logic        flush, redirect_valid;
    logic [4:0]  redirect_pc;
    logic        res_err;
    logic [2:0]  fifo_count;
    logic [7:0]  resolve_cnt, mispred_cnt;

    typedef struct packed {
        logic       br;
        logic       flag;
        logic [2:0] cls;
        logic       rv;
        logic [4:0] pc;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    branch_resolver dut (
        .clk            (clk),
        .resetn         (resetn),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .pred_fallthru  (pred_fallthru),
        .pred_cls       (pred_cls),
        .pred_ready     (pred_ready),
        .res_valid      (res_valid),
        .res_funct3     (res_funct3),
        .res_rs1        (res_rs1),
        .res_rs2        (res_rs2),
        .upd_branch     (upd_branch),
        .upd_flag       (upd_flag),
        .upd_cls        (upd_cls),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .res_err        (res_err),
        .fifo_count     (fifo_count),
        .resolve_cnt    (resolve_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic exp_t mk(input logic br, input logic flag, input logic [2:0] cls,
                                input logic rv, input logic [4:0] pc, input logic err);
        exp_t e;
        e.br = br; e.flag = flag; e.cls = cls; e.rv = rv; e.pc = pc; e.err = err;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pred(input logic v, input logic t, input logic [4:0] tg,
                            input logic [4:0] ft, input logic [2:0] c);
        pred_valid = v; pred_taken = t; pred_target = tg; pred_fallthru = ft; pred_cls = c;
    endtask

    task automatic set_res(input logic v, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b);
        res_valid = v; res_funct3 = f3; res_rs1 = a; res_rs2 = b;
    endtask

    task automatic push1(input logic t, input logic [4:0] tg, input logic [4:0] ft,
                         input logic [2:0] c);
        set_pred(1'b1, t, tg, ft, c);
        step();
        set_pred(1'b0, 1'b0, 5'd0, 5'd0, 3'd0);
    endtask

    task automatic resolve1(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input exp_t e);
        set_res(1'b1, f3, a, b);
        exp_q.push_back(e);
        step();
        set_res(1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pred_ready"}, pred_ready, 1);
        chk({tag, "_upd"}, {upd_branch, upd_flag, upd_cls}, 0);
        chk({tag, "_flush"}, flush, 0);
        chk({tag, "_redirect"}, {redirect_valid, redirect_pc}, 0);
        chk({tag, "_err"}, res_err, 0);
        chk({tag, "_fifo_count"}, fifo_count, 0);
        chk({tag, "_counters"}, {resolve_cnt, mispred_cnt}, 0);
    endtask

    // Monitor: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (resetn && (upd_branch || res_err || redirect_valid)) begin
            if (exp_q.size() == 0) begin
                chk("mon_spurious_strobe", {upd_branch, res_err, redirect_valid}, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_upd_branch", upd_branch, e.br);
                chk("mon_res_err", res_err, e.err);
                chk("mon_redirect_valid", redirect_valid, e.rv);
                if (e.br) begin
                    chk("mon_upd_flag", upd_flag, e.flag);
                    chk("mon_upd_cls", upd_cls, e.cls);
                end
                if (e.rv) chk("mon_redirect_pc", redirect_pc, e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        set_pred(1'b0, 1'b0, 5'd0, 5'd0, 3'd0);
        set_res(1'b0, 3'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        resetn = 1'b1;
        step();

        // 1: correctly predicted taken BEQ
        push1(1'b1, 5'd12, 5'd4, 3'd3);
        chk("t1_fifo_count", fifo_count, 1);
        resolve1(3'b000, 32'd7, 32'd7, mk(1, 1, 3, 0, 0, 0));
        chk("t1_resolve_cnt", resolve_cnt, 1);
        chk("t1_flush", flush, 0);
        chk("t1_fifo_empty", fifo_count, 0);

        // 2: signed BLT not taken, predicted taken -> redirect to fallthru;
        //    a push in the mispredict cycle is wrong-path and discarded
        push1(1'b1, 5'd20, 5'd9, 3'd1);
        set_pred(1'b1, 1'b1, 5'd2, 5'd3, 3'd0);
        resolve1(3'b100, 32'd5, 32'hFFFF_FFFD, mk(1, 0, 1, 1, 9, 0));
        set_pred(1'b0, 1'b0, 5'd0, 5'd0, 3'd0);
        chk("t2_flush_c1", flush, 1);
        chk("t2_pred_ready", pred_ready, 0);
        chk("t2_fifo_cleared", fifo_count, 0);
        chk("t2_mispred_cnt", mispred_cnt, 1);
        chk("t2_resolve_cnt", resolve_cnt, 2);

        // 4: res_valid and pred_valid during flush are ignored
        set_res(1'b1, 3'b000, 32'd1, 32'd1);
        set_pred(1'b1, 1'b0, 5'd1, 5'd2, 3'd5);
        step();
        chk("t4_flush_c2", flush, 1);
        chk("t4_fifo_in_flush", fifo_count, 0);
        step();
        set_res(1'b0, 3'd0, 32'd0, 32'd0);
        set_pred(1'b0, 1'b0, 5'd0, 5'd0, 3'd0);
        chk("t4_flush_done", flush, 0);
        chk("t4_fifo_after", fifo_count, 0);
        chk("t4_pred_ready", pred_ready, 1);
        push1(1'b1, 5'd30, 5'd31, 3'd5);
        chk("t4_first_push", fifo_count, 1);
        resolve1(3'b111, 32'd3, 32'd2, mk(1, 1, 5, 0, 0, 0));

        // 3: fill, drop when full, simultaneous pop+push, order preserved
        for (int i = 0; i < 4; i++) push1(1'b0, 5'(10 + i), 5'(20 + i), 3'(i));
        chk("t3_full_count", fifo_count, 4);
        chk("t3_full_ready", pred_ready, 0);
        push1(1'b1, 5'd1, 5'd1, 3'd6);
        chk("t3_drop_when_full", fifo_count, 4);
        set_pred(1'b1, 1'b0, 5'd14, 5'd24, 3'd4);
        resolve1(3'b001, 32'd9, 32'd9, mk(1, 0, 0, 0, 0, 0));
        set_pred(1'b0, 1'b0, 5'd0, 5'd0, 3'd0);
        chk("t3_pop_push_count", fifo_count, 4);
        for (int i = 1; i <= 4; i++) resolve1(3'b001, 32'd9, 32'd9, mk(1, 0, 3'(i), 0, 0, 0));
        chk("t3_drained", fifo_count, 0);
        chk("t3_resolve_cnt", resolve_cnt, 8);

        // 5: resolve with empty FIFO, then illegal funct3 pops and trains
        resolve1(3'b000, 32'd0, 32'd0, mk(0, 0, 0, 0, 0, 1));
        chk("t5_empty_no_count", resolve_cnt, 8);
        push1(1'b0, 5'd7, 5'd8, 3'd6);
        resolve1(3'b010, 32'd5, 32'd5, mk(1, 0, 6, 0, 0, 1));
        chk("t5_illegal_popped", fifo_count, 0);
        chk("t5_resolve_cnt", resolve_cnt, 9);

        // Signed BGE taken, correct; unsigned BLTU taken, mispredicted -> target
        push1(1'b1, 5'd1, 5'd2, 3'd3);
        resolve1(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(1, 1, 3, 0, 0, 0));
        push1(1'b0, 5'd17, 5'd18, 3'd2);
        resolve1(3'b110, 32'd1, 32'hFFFF_FFFF, mk(1, 1, 2, 1, 17, 0));
        chk("bltu_mispred_cnt", mispred_cnt, 2);
        chk("bltu_flush", flush, 1);
        step();
        step();
        chk("bltu_flush_done", flush, 0);

        // 6: fresh reset, then counter saturation
        resetn = 1'b0;
        step();
        chk_reset_outputs("reset2");
        resetn = 1'b1;
        step();
        for (int i = 0; i < 300; i++) begin
            push1(1'b1, 5'd3, 5'd4, 3'd7);
            resolve1(3'b111, 32'hFFFF_FFFF, 32'd1, mk(1, 1, 7, 0, 0, 0));
        end
        chk("t6_resolve_sat", resolve_cnt, 255);
        chk("t6_mispred_zero", mispred_cnt, 0);

        // Reset in the middle of a flush clears everything at once
        push1(1'b1, 5'd5, 5'd6, 3'd2);
        resolve1(3'b000, 32'd1, 32'd2, mk(1, 0, 2, 1, 6, 0));
        step();
        chk("t6_flush_before_reset", flush, 1);
        resetn = 1'b0;
        #1;
        chk_reset_outputs("midflush_reset");
        step();
        resetn = 1'b1;
        step();

        chk("pending_expectations", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
